// File: rtl/rr_elastic_bypass_pipe_if.sv
// rr_elastic_bypass_pipe_if
// Groups the two elastic handshakes of the register-read stage into one bundle.
//   Upstream side : in_valid_i / in_ready_o plus the issued entry (payload,
//                   source tags, CSR flag and CSR address).
//   Downstream side: out_valid_o / out_ready_i plus payload and both operands.
// Signal names keep the _i/_o suffix as seen from the pipe itself.
//   slave  : used by the pipe (consumes the entry, produces the operands).
//   master : used by whatever drives the pipe (issue side + FU side together).
interface rr_elastic_bypass_pipe_if #(
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 7,
    parameter int PAYLOAD_W  = 128,
    parameter int CSR_ADDR_W = 12
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [PAYLOAD_W-1:0]  in_payload_i;
    logic [TAG_W-1:0]      in_tag1_i;
    logic [TAG_W-1:0]      in_tag2_i;
    logic                  in_is_csr_i;
    logic [CSR_ADDR_W-1:0] in_csr_addr_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [PAYLOAD_W-1:0]  out_payload_o;
    logic [DATA_W-1:0]     out_src1_o;
    logic [DATA_W-1:0]     out_src2_o;

    modport slave (
        input  in_valid_i, in_payload_i, in_tag1_i, in_tag2_i, in_is_csr_i, in_csr_addr_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, out_payload_o, out_src1_o, out_src2_o
    );

    modport master (
        output in_valid_i, in_payload_i, in_tag1_i, in_tag2_i, in_is_csr_i, in_csr_addr_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, out_payload_o, out_src1_o, out_src2_o
    );
endinterface

// File: rtl/rr_elastic_bypass_pipe.sv
// rr_elastic_bypass_pipe
// Register-read stage between the issue/payload RAM and a functional unit.
// Entries flow through DEPTH elastic stages with bubble collapse. Every valid
// stage keeps snooping the bypass network (held or moving), so operands that
// are stalled still pick up late results. CSR entries take source 2 from the
// CSR read port and never snoop it.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   flush_i         kills every in-flight entry at the next edge
//   bus (slave)     upstream in_* handshake and downstream out_* handshake
//   rf_tag*_o / rf_data*_i      same-cycle register-file read
//   csr_rd_en_o / csr_rd_addr_o / csr_data_i   same-cycle CSR read
//   byp_valid_i / byp_tag_i / byp_data_i       BYP_CH bypass channels, lowest wins
//   occupancy_o     number of valid stages
module rr_elastic_bypass_pipe #(
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 7,
    parameter int PAYLOAD_W  = 128,
    parameter int DEPTH      = 2,
    parameter int BYP_CH     = 4,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    rr_elastic_bypass_pipe_if.slave  bus,
    output logic [TAG_W-1:0]         rf_tag1_o,
    output logic [TAG_W-1:0]         rf_tag2_o,
    input  logic [DATA_W-1:0]        rf_data1_i,
    input  logic [DATA_W-1:0]        rf_data2_i,
    output logic                     csr_rd_en_o,
    output logic [CSR_ADDR_W-1:0]    csr_rd_addr_o,
    input  logic [DATA_W-1:0]        csr_data_i,
    input  logic [BYP_CH-1:0]        byp_valid_i,
    input  logic [BYP_CH*TAG_W-1:0]  byp_tag_i,
    input  logic [BYP_CH*DATA_W-1:0] byp_data_i,
    output logic [2:0]               occupancy_o
);
    localparam int LAST = DEPTH - 1;

    // Returns base unless a bypass channel carries this tag; scanning from the
    // top channel down lets the lowest matching channel have the final word.
    function automatic logic [DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]         tag,
        input logic [DATA_W-1:0]        base,
        input logic [BYP_CH-1:0]        bv,
        input logic [BYP_CH*TAG_W-1:0]  bt,
        input logic [BYP_CH*DATA_W-1:0] bd
    );
        logic [DATA_W-1:0] r;
        r = base;
        for (int k = BYP_CH - 1; k >= 0; k--) begin
            if (bv[k] && (bt[k*TAG_W +: TAG_W] == tag)) begin
                r = bd[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     is_csr_q, is_csr_d;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [TAG_W-1:0]     tag1_q    [DEPTH];
    logic [TAG_W-1:0]     tag1_d    [DEPTH];
    logic [TAG_W-1:0]     tag2_q    [DEPTH];
    logic [TAG_W-1:0]     tag2_d    [DEPTH];
    logic [DATA_W-1:0]    data1_q   [DEPTH];
    logic [DATA_W-1:0]    data1_d   [DEPTH];
    logic [DATA_W-1:0]    data2_q   [DEPTH];
    logic [DATA_W-1:0]    data2_d   [DEPTH];
    logic [2:0]           occupancy_q, occupancy_d;

    logic [DATA_W-1:0]    snp1 [DEPTH];
    logic [DATA_W-1:0]    snp2 [DEPTH];
    logic [DEPTH-1:0]     adv;
    logic                 in_ready;
    logic                 accept;
    logic [DATA_W-1:0]    new1, new2;

    // A stage can take new contents unless it and every stage after it are
    // full while the FU stalls; this is the advance chain in closed form.
    always_comb begin
        logic full;
        adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            full = 1'b1;
            for (int j = k; j < DEPTH; j++) begin
                full = full & valid_q[j];
            end
            adv[k] = bus.out_ready_i | ~full;
        end
    end

    // Reset is folded in so nothing is accepted or strobed while held in reset.
    assign in_ready       = reset & adv[0] & ~flush_i;
    assign accept         = bus.in_valid_i & in_ready;
    assign bus.in_ready_o = in_ready;
    assign csr_rd_en_o    = bus.in_valid_i & bus.in_is_csr_i & in_ready;
    assign csr_rd_addr_o  = bus.in_csr_addr_i;
    assign rf_tag1_o      = bus.in_tag1_i;
    assign rf_tag2_o      = bus.in_tag2_i;

    // Current-cycle view of each stage's operands with bypass applied; invalid
    // stages are left alone so a cleared pipe shows zero operands.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            snp1[k] = data1_q[k];
            snp2[k] = data2_q[k];
            if (valid_q[k]) begin
                snp1[k] = snoop(tag1_q[k], data1_q[k], byp_valid_i, byp_tag_i, byp_data_i);
                if (!is_csr_q[k]) begin
                    snp2[k] = snoop(tag2_q[k], data2_q[k], byp_valid_i, byp_tag_i, byp_data_i);
                end
            end
        end
    end

    // Operands for the entry arriving this cycle; a CSR entry's source 2 comes
    // straight from the CSR port.
    always_comb begin
        new1 = snoop(bus.in_tag1_i, rf_data1_i, byp_valid_i, byp_tag_i, byp_data_i);
        new2 = bus.in_is_csr_i ? csr_data_i
                               : snoop(bus.in_tag2_i, rf_data2_i, byp_valid_i, byp_tag_i, byp_data_i);
    end

    // Next-state: hold with snooped operands by default, shift forward where a
    // stage advances, load S0 on acceptance, and let flush clear every valid.
    always_comb begin
        valid_d  = valid_q;
        is_csr_d = is_csr_q;
        for (int k = 0; k < DEPTH; k++) begin
            payload_d[k] = payload_q[k];
            tag1_d[k]    = tag1_q[k];
            tag2_d[k]    = tag2_q[k];
            data1_d[k]   = snp1[k];
            data2_d[k]   = snp2[k];
        end
        for (int k = LAST; k >= 1; k--) begin
            if (adv[k]) begin
                valid_d[k]   = valid_q[k-1];
                is_csr_d[k]  = is_csr_q[k-1];
                payload_d[k] = payload_q[k-1];
                tag1_d[k]    = tag1_q[k-1];
                tag2_d[k]    = tag2_q[k-1];
                data1_d[k]   = snp1[k-1];
                data2_d[k]   = snp2[k-1];
            end
        end
        if (adv[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                is_csr_d[0]  = bus.in_is_csr_i;
                payload_d[0] = bus.in_payload_i;
                tag1_d[0]    = bus.in_tag1_i;
                tag2_d[0]    = bus.in_tag2_i;
                data1_d[0]   = new1;
                data2_d[0]   = new2;
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
        occupancy_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy_d = occupancy_d + 3'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            is_csr_q    <= '0;
            occupancy_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                payload_q[k] <= '0;
                tag1_q[k]    <= '0;
                tag2_q[k]    <= '0;
                data1_q[k]   <= '0;
                data2_q[k]   <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            is_csr_q    <= is_csr_d;
            occupancy_q <= occupancy_d;
            for (int k = 0; k < DEPTH; k++) begin
                payload_q[k] <= payload_d[k];
                tag1_q[k]    <= tag1_d[k];
                tag2_q[k]    <= tag2_d[k];
                data1_q[k]   <= data1_d[k];
                data2_q[k]   <= data2_d[k];
            end
        end
    end

    // Flush gates the output handshake in the same cycle it is raised.
    assign bus.out_valid_o   = valid_q[LAST] & ~flush_i;
    assign bus.out_payload_o = payload_q[LAST];
    assign bus.out_src1_o    = snp1[LAST];
    assign bus.out_src2_o    = snp2[LAST];
    assign occupancy_o       = occupancy_q;
endmodule
